harz_bus_arbiter: RTL

- Multi-host successor to the single-host Harz/Z80 slot-bus mux.
- Arbitrates NUM_HOSTS Harz-style transaction requesters plus the pass-through Z80 CPU onto one registered MSX slot bus.
- Grants are round-robin with configurable setup delay; CPU bus cycles are never cut mid-cycle.
- Sits between the CPU/host masters and BasicSlotUnit.

---
 rtl/harz_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/harz_bus_arbiter.sv
// Round-robin arbiter: NUM_HOSTS Harz transaction requesters plus the pass-through Z80 onto one registered MSX slot bus.
// Optional access timeout with abort pulse is enabled by defining HARZ_ARB_TIMEOUT_EN.
module harz_bus_arbiter #(
    parameter int NUM_HOSTS      = 2,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    i_CLK,
    input  logic                    i_RST_n,
    input  logic [3*NUM_HOSTS-1:0]  i_host_req,
    input  logic [16*NUM_HOSTS-1:0] i_host_addr,
    input  logic [8*NUM_HOSTS-1:0]  i_host_wdata,
    output logic [NUM_HOSTS-1:0]    o_host_busy,
    output logic [NUM_HOSTS-1:0]    o_host_done,
    output logic [NUM_HOSTS-1:0]    o_host_err,
    output logic [7:0]              o_host_rdata,
    input  logic                    i_z80_mreq_n,
    input  logic                    i_z80_iorq_n,
    input  logic                    i_z80_rd_n,
    input  logic                    i_z80_wr_n,
    input  logic [15:0]             i_z80_a,
    input  logic [7:0]              i_z80_dout,
    output logic                    o_z80_wait_n,
    output logic [7:0]              o_z80_di,
    output logic                    o_slot_merq,
    output logic                    o_slot_iorq,
    output logic                    o_slot_rd,
    output logic                    o_slot_wr,
    output logic [15:0]             o_slot_a,
    output logic [7:0]              o_slot_wdata,
    input  logic [7:0]              i_slot_rdata,
    input  logic                    i_slot_busy
);

    localparam int PW   = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    // One counter serves both the setup delay and the access timeout.
    localparam int CMAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_FINISH
    } state_t;

    state_t                 r_state;
    logic                   r_owner_host;
    logic [PW-1:0]          r_owner;
    logic [PW-1:0]          r_rr;
    logic [NUM_HOSTS-1:0]   r_armed;
    logic [NUM_HOSTS-1:0]   r_busy;
    logic [NUM_HOSTS-1:0]   r_done;
    logic [CW-1:0]          r_cnt;
    logic [7:0]             r_rdata;
    logic                   r_slot_merq;
    logic                   r_slot_iorq;
    logic                   r_slot_rd;
    logic                   r_slot_wr;
    logic [15:0]            r_slot_a;
    logic [7:0]             r_slot_wdata;
`ifdef HARZ_ARB_TIMEOUT_EN
    logic [NUM_HOSTS-1:0]   r_err;
`endif

    logic [NUM_HOSTS-1:0]   w_valid;
    logic [NUM_HOSTS-1:0]   w_cand;
    logic                   w_found;
    logic [PW-1:0]          w_win;
    logic [PW-1:0]          w_rr_next;
    logic [2:0]             w_win_code;
    logic [15:0]            w_win_addr;
    logic [7:0]             w_win_wdata;
    logic                   w_dec_merq;
    logic                   w_dec_iorq;
    logic                   w_dec_rd;
    logic                   w_dec_wr;
    logic                   w_cpu_idle;
    logic                   w_cpu_blocked;
    logic                   w_grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_HOSTS; gi++) begin : g_host
            logic [2:0] w_code;
            assign w_code      = i_host_req[3*gi +: 3];
            assign w_valid[gi] = (w_code >= 3'd1) && (w_code <= 3'd4);
            assign w_cand[gi]  = r_armed[gi] & w_valid[gi];
        end
    endgenerate

    // First armed requester at or after the round-robin pointer.
    always_comb begin : p_pick
        int w_idx;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_HOSTS; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NUM_HOSTS) begin
                w_idx = w_idx - NUM_HOSTS;
            end
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
    end

    assign w_win_code  = i_host_req[int'(w_win)*3 +: 3];
    assign w_win_addr  = i_host_addr[int'(w_win)*16 +: 16];
    assign w_win_wdata = i_host_wdata[int'(w_win)*8 +: 8];
    assign w_rr_next   = (w_win == PW'(NUM_HOSTS - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_dec_merq = (w_win_code == 3'd1) || (w_win_code == 3'd2);
        w_dec_iorq = (w_win_code == 3'd3) || (w_win_code == 3'd4);
        w_dec_rd   = (w_win_code == 3'd1) || (w_win_code == 3'd3);
        w_dec_wr   = (w_win_code == 3'd2) || (w_win_code == 3'd4);
    end

    assign w_cpu_idle    = i_z80_mreq_n & i_z80_iorq_n;
    assign w_cpu_blocked = r_owner_host & ~w_cpu_idle;
    assign w_grant       = (r_state == S_IDLE) && w_found && w_cpu_idle;

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_state      <= S_IDLE;
            r_owner_host <= 1'b0;
            r_owner      <= '0;
            r_rr         <= '0;
            r_armed      <= '1;
            r_busy       <= '0;
            r_done       <= '0;
            r_cnt        <= '0;
            r_rdata      <= 8'h00;
            r_slot_merq  <= 1'b0;
            r_slot_iorq  <= 1'b0;
            r_slot_rd    <= 1'b0;
            r_slot_wr    <= 1'b0;
            r_slot_a     <= 16'h0000;
            r_slot_wdata <= 8'h00;
`ifdef HARZ_ARB_TIMEOUT_EN
            r_err        <= '0;
`endif
        end else begin
            r_done <= '0;
`ifdef HARZ_ARB_TIMEOUT_EN
            r_err  <= '0;
`endif
            // A host must present NONE once before it can be served again.
            for (int h = 0; h < NUM_HOSTS; h++) begin
                if (!w_valid[h]) begin
                    r_armed[h] <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_slot_merq    <= w_dec_merq;
                        r_slot_iorq    <= w_dec_iorq;
                        r_slot_rd      <= w_dec_rd;
                        r_slot_wr      <= w_dec_wr;
                        r_slot_a       <= w_win_addr;
                        r_slot_wdata   <= w_win_wdata;
                        r_owner_host   <= 1'b1;
                        r_owner        <= w_win;
                        r_busy[w_win]  <= 1'b1;
                        r_armed[w_win] <= 1'b0;
                        r_rr           <= w_rr_next;
                        r_cnt          <= '0;
                        r_state        <= S_SETUP;
                    end else begin
                        r_slot_merq    <= ~i_z80_mreq_n;
                        r_slot_iorq    <= ~i_z80_iorq_n;
                        r_slot_rd      <= ~i_z80_rd_n;
                        r_slot_wr      <= ~i_z80_wr_n;
                        r_slot_a       <= i_z80_a;
                        r_slot_wdata   <= i_z80_dout;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (!i_slot_busy) begin
                        r_slot_rd       <= 1'b0;
                        r_slot_wr       <= 1'b0;
                        if (r_slot_rd) begin
                            r_rdata     <= i_slot_rdata;
                        end
                        r_busy          <= '0;
                        r_done[r_owner] <= 1'b1;
                        r_state         <= S_FINISH;
                    end
`ifdef HARZ_ARB_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_slot_rd      <= 1'b0;
                        r_slot_wr      <= 1'b0;
                        r_rdata        <= 8'hFF;
                        r_busy         <= '0;
                        r_err[r_owner] <= 1'b1;
                        r_state        <= S_FINISH;
                    end else begin
                        r_cnt          <= r_cnt + 1'b1;
                    end
`endif
                end
                S_FINISH: begin
                    r_slot_merq  <= 1'b0;
                    r_slot_iorq  <= 1'b0;
                    r_owner_host <= 1'b0;
                    r_owner      <= '0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_host_busy  = r_busy;
    assign o_host_done  = r_done;
`ifdef HARZ_ARB_TIMEOUT_EN
    assign o_host_err   = r_err;
`else
    assign o_host_err   = '0;
`endif
    assign o_host_rdata = r_rdata;
    assign o_z80_di     = i_slot_rdata;
    assign o_z80_wait_n = ~(i_slot_busy | w_cpu_blocked);
    assign o_slot_merq  = r_slot_merq;
    assign o_slot_iorq  = r_slot_iorq;
    assign o_slot_rd    = r_slot_rd;
    assign o_slot_wr    = r_slot_wr;
    assign o_slot_a     = r_slot_a;
    assign o_slot_wdata = r_slot_wdata;

endmodule
